// File: rtl/ir_pulse_scheduler_if.sv
// Pulse-queue handshake bundle for ir_pulse_scheduler.
// A code source drives the master side and the scheduler sits on the slave side.
//   pulse_valid_in   master->slave  an entry is offered
//   pulse_ready_out  slave->master  the queue can accept the entry
//   pulse_mark_in    master->slave  mark (carrier on) duration
//   pulse_space_in   master->slave  space (LED off) duration
//   pulse_last_in    master->slave  this entry ends the code
interface ir_pulse_scheduler_if #(
  parameter int DELAY_WIDTH = 16
);
  logic                   pulse_valid_in;
  logic                   pulse_ready_out;
  logic [DELAY_WIDTH-1:0] pulse_mark_in;
  logic [DELAY_WIDTH-1:0] pulse_space_in;
  logic                   pulse_last_in;

  modport master (
    output pulse_valid_in, pulse_mark_in, pulse_space_in, pulse_last_in,
    input  pulse_ready_out
  );

  modport slave (
    input  pulse_valid_in, pulse_mark_in, pulse_space_in, pulse_last_in,
    output pulse_ready_out
  );
endinterface

// File: rtl/ir_pulse_scheduler.sv
// ir_pulse_scheduler
// Buffers (mark, space, last) entries and plays them through the shared
// ctc_generator / delay_timer pair: carrier on for the mark, LED off for the
// space.
//   clock_in, reset_in        clock, synchronous active-high reset
//   carrier_value_in/load_in  carrier half-period load (honoured in IDLE only)
//   pulse_if (slave)          valid/ready entry queue
//   abort_in                  stop immediately, flush the queue
//   ctc_*_out                 to ctc_generator
//   delay_*_out, delay_busy_in  to/from delay_timer
//   busy_out                  sequencer not idle
//   done_out                  one-cycle pulse when a last entry completes
//   underrun_out              sticky: queue ran dry in the middle of a code
module ir_pulse_scheduler #(
  parameter int CTC_WIDTH   = 8,
  parameter int DELAY_WIDTH = 16,
  parameter int DEPTH       = 4
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic [CTC_WIDTH-1:0]   carrier_value_in,
  input  logic                   carrier_load_in,
  ir_pulse_scheduler_if.slave    pulse_if,
  input  logic                   abort_in,
  output logic                   ctc_enable_out,
  output logic                   ctc_forced_out,
  output logic                   ctc_wr_strobe_out,
  output logic [CTC_WIDTH-1:0]   ctc_value_out,
  output logic                   delay_enable_out,
  output logic                   delay_start_strobe_out,
  output logic [DELAY_WIDTH-1:0] delay_value_out,
  input  logic                   delay_busy_in,
  output logic                   busy_out,
  output logic                   done_out,
  output logic                   underrun_out
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE, LOAD_MARK, MARK_ARM, MARK, LOAD_SPACE, SPACE_ARM, SPACE
  } state_t;

  state_t state, state_d;

  // ---------------- entry queue ----------------
  logic [DELAY_WIDTH-1:0] q_mark  [DEPTH];
  logic [DELAY_WIDTH-1:0] q_space [DEPTH];
  logic                   q_last  [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   full, empty, push, pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign pop   = (state == LOAD_MARK);
  // A pop in LOAD_MARK frees a slot in the same cycle, so a full queue can
  // still take an entry then.
  assign pulse_if.pulse_ready_out = !reset_in && (!full || pop);
  assign push  = pulse_if.pulse_valid_in && pulse_if.pulse_ready_out && !abort_in;

  always_ff @(posedge clock_in) begin
    if (reset_in || abort_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (push) begin
      q_mark[wr_ptr]  <= pulse_if.pulse_mark_in;
      q_space[wr_ptr] <= pulse_if.pulse_space_in;
      q_last[wr_ptr]  <= pulse_if.pulse_last_in;
    end
  end

  // Entry that LOAD_MARK will work on. From an empty queue in IDLE it is the
  // one being pushed right now, so the mark strobe can already be visible in
  // the LOAD_MARK cycle.
  logic [DELAY_WIDTH-1:0] head_mark, head_space;
  logic                   head_last;

  always_comb begin
    if (empty) begin
      head_mark  = pulse_if.pulse_mark_in;
      head_space = pulse_if.pulse_space_in;
      head_last  = pulse_if.pulse_last_in;
    end else begin
      head_mark  = q_mark[rd_ptr];
      head_space = q_space[rd_ptr];
      head_last  = q_last[rd_ptr];
    end
  end

  // ---------------- sequencer ----------------
  logic [DELAY_WIDTH-1:0] work_mark, work_space;
  logic                   work_last;
  logic                   space_exit, done_d, underrun_d;

  assign space_exit = ((state == LOAD_SPACE) && (work_space == '0)) ||
                      ((state == SPACE) && !delay_busy_in);

  always_comb begin
    state_d    = state;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    case (state)
      IDLE:       if (!empty || push) state_d = LOAD_MARK;
      LOAD_MARK:  state_d = (work_mark != '0) ? MARK_ARM : LOAD_SPACE;
      MARK_ARM:   state_d = MARK;
      MARK:       if (!delay_busy_in) state_d = LOAD_SPACE;
      LOAD_SPACE: if (work_space != '0) state_d = SPACE_ARM;
      SPACE_ARM:  state_d = SPACE;
      SPACE:      state_d = SPACE;
      default:    state_d = IDLE;
    endcase
    if (space_exit) begin
      if (work_last) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else if (!empty) begin
        state_d = LOAD_MARK;
      end else begin
        underrun_d = 1'b1;
        state_d    = IDLE;
      end
    end
    if (abort_in) begin
      state_d    = IDLE;
      done_d     = 1'b0;
      underrun_d = 1'b0;
    end
  end

  assign ctc_forced_out = 1'b0;

  // Outputs are registered from the next state so each level and strobe
  // lines up with the state it belongs to.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state                  <= IDLE;
      work_mark              <= '0;
      work_space             <= '0;
      work_last              <= 1'b0;
      ctc_enable_out         <= 1'b0;
      ctc_wr_strobe_out      <= 1'b0;
      ctc_value_out          <= '0;
      delay_enable_out       <= 1'b0;
      delay_start_strobe_out <= 1'b0;
      delay_value_out        <= '0;
      busy_out               <= 1'b0;
      done_out               <= 1'b0;
      underrun_out           <= 1'b0;
    end else begin
      state                  <= state_d;
      ctc_enable_out         <= (state_d == MARK_ARM) || (state_d == MARK);
      delay_enable_out       <= (state_d != IDLE);
      busy_out               <= (state_d != IDLE);
      done_out               <= done_d;
      ctc_wr_strobe_out      <= 1'b0;
      delay_start_strobe_out <= 1'b0;

      if ((state == IDLE) && carrier_load_in && !abort_in) begin
        ctc_value_out     <= carrier_value_in;
        ctc_wr_strobe_out <= 1'b1;
      end

      if (underrun_d)
        underrun_out <= 1'b1;
      else if ((state == IDLE) && (state_d == LOAD_MARK))
        underrun_out <= 1'b0;

      if (state_d == LOAD_MARK) begin
        work_mark  <= head_mark;
        work_space <= head_space;
        work_last  <= head_last;
        if (head_mark != '0) begin
          delay_value_out        <= head_mark;
          delay_start_strobe_out <= 1'b1;
        end
      end else if ((state_d == LOAD_SPACE) && (work_space != '0)) begin
        delay_value_out        <= work_space;
        delay_start_strobe_out <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ir_pulse_scheduler.md
# ir_pulse_scheduler

Buffered mark/space sequencer between a code source (the controller or a future host port) and the shared `ctc_generator`/`delay_timer` pair. It accepts (mark, space) duration pairs through a valid/ready queue and plays each one. During the mark it gates the IR carrier on for the programmed time; during the space it holds the LED off. Its `ctc_*` and `delay_*` outputs connect one-to-one to the existing generator and timer ports, so a code source only has to push entries.

## Interface
- `CTC_WIDTH`, default 8: carrier half-period width.
- `DELAY_WIDTH`, default 16: mark/space duration width, in timer units.
- `DEPTH`, default 4: pulse queue depth; must be a power of 2, ≥2.

- `clock_in`  in  1  clock; all logic on rising edge.
- `reset_in`  in  1  synchronous, active-high reset.
- `carrier_value_in`  in  CTC_WIDTH  carrier half-period in counts.
- `carrier_load_in`  in  1  strobe; loads `carrier_value_in` (IDLE only).
- `pulse_valid_in`  in  1  queue entry offered.
- `pulse_ready_out`  out  1  queue can accept an entry.
- `pulse_mark_in`  in  DELAY_WIDTH  mark (carrier on) duration.
- `pulse_space_in`  in  DELAY_WIDTH  space (LED off) duration.
- `pulse_last_in`  in  1  entry ends the code.
- `abort_in`  in  1  stop immediately and flush.
- `ctc_enable_out`  out  1  to `ctc_generator.enable_in`.
- `ctc_forced_out`  out  1  to `forced_in`; constant 0 (LED off).
- `ctc_wr_strobe_out`  out  1  to `update_comp_value_in`.
- `ctc_value_out`  out  CTC_WIDTH  to `compare_value_in`.
- `delay_enable_out`  out  1  to `delay_timer.enable_in`.
- `delay_start_strobe_out`  out  1  to `update_delay_in`.
- `delay_value_out`  out  DELAY_WIDTH  to `delay_in`.
- `delay_busy_in`  in  1  from `delay_timer.busy_out`.
- `busy_out`  out  1  high in any state except IDLE.
- `done_out`  out  1  one-cycle pulse when a `last` entry completes.
- `underrun_out`  out  1  sticky; queue ran dry mid-code.

## Operation
- **Queue:**
  - DEPTH-entry FIFO of {mark, space, last}.
  - A push happens when `pulse_valid_in && pulse_ready_out`.
  - `pulse_ready_out` = !full; pushes are accepted in every state.
  - Pops happen only in LOAD_MARK.
- **States:** IDLE, LOAD_MARK, MARK_ARM, MARK, LOAD_SPACE, SPACE_ARM, SPACE.
- **IDLE:**
  - Queue non-empty → LOAD_MARK, and `underrun_out` clears.
  - `carrier_load_in` → `ctc_value_out` <= `carrier_value_in`, `ctc_wr_strobe_out` = 1 for one cycle.
  - `carrier_load_in` is ignored outside IDLE.
- **LOAD_MARK:**
  - Pop the head entry into working registers.
  - mark ≠ 0 → `delay_value_out` = mark, `delay_start_strobe_out` = 1, go to MARK_ARM.
  - mark = 0 → go to LOAD_SPACE.
- **MARK_ARM:** one cycle; `delay_busy_in` is ignored. Go to MARK.
- **MARK:** hold while `delay_busy_in` = 1; on 0 go to LOAD_SPACE.
- **LOAD_SPACE:**
  - space ≠ 0 → strobe with space, go to SPACE_ARM.
  - space = 0 → apply the SPACE exit rule immediately.
- **SPACE_ARM / SPACE:** same as MARK_ARM / MARK.
- **SPACE exit rule:**
  - last = 1 → `done_out` = 1, go to IDLE.
  - else queue non-empty → LOAD_MARK.
  - else → `underrun_out` <= 1, go to IDLE (LED off).
- **Output levels:**
  - `ctc_enable_out` = 1 in MARK_ARM and MARK only.
  - `delay_enable_out` = 1 in every state except IDLE.
- **Abort:** `abort_in` overrides everything.
  - Next state is IDLE and the FIFO is flushed.
  - Both enables drop and no `done_out` is generated.
  - `underrun_out` is unchanged.
  - Any push offered in the same cycle is discarded.

## Timing
- **Reset values:**
  - All outputs 0, including `pulse_ready_out` while `reset_in` is high.
  - `ctc_value_out` = 0; FIFO empty; state IDLE.
  - `pulse_ready_out` = 1 in the first cycle after reset.
- **Start latency:**
  - Entry pushed in cycle N (queue was empty, IDLE) → LOAD_MARK in cycle N+1.
  - `delay_start_strobe_out` and the pop occur in N+1.
  - `ctc_enable_out` rises in N+2.
- **Mark duration:** carrier runs from MARK_ARM until the first cycle `delay_busy_in` is sampled low in MARK, plus that cycle.
- **Back-to-back entries:** 1 cycle of LOAD_MARK overhead between SPACE exit and the next mark strobe.
- **Registered outputs:** every output is registered except `pulse_ready_out`.
- **Push while full:** dropped, since ready is 0. When full, a pop and a push in the same cycle are both accepted.
- **Abort timing:** in cycle N, `ctc_enable_out` = 0 and `busy_out` = 0 from N+1.

## Test plan
- **Carrier load:** `carrier_load_in` with value 0x1A in IDLE → `ctc_wr_strobe_out` high for one cycle, `ctc_value_out` = 0x1A. The same strobe while busy → no strobe.
- **Single entry:** push {mark=5, space=3, last=1} against a timer model:
  - One strobe with 5, `ctc_enable_out` high through MARK.
  - Then one strobe with 3, `ctc_enable_out` low.
  - `done_out` single pulse, then `busy_out` = 0.
- **Queue back-pressure:** push 6 entries (last on the 6th) with the sequencer stalled in a long mark (DEPTH=4):
  - `pulse_ready_out` deasserts after 4 queued.
  - All 6 entries play in order.
  - Exactly one `done_out`.
- **Zero durations:** {mark=0, space=4, last=0} then {mark=2, space=0, last=1}:
  - No mark strobe for entry 1; no space strobe for entry 2.
  - `ctc_enable_out` asserts only for entry 2.
  - `done_out` fires.
- **Underrun:** push {mark=2, space=2, last=0} only → after the space, `underrun_out` = 1 and IDLE. The next push clears it at start.
- **Abort and reset mid-operation:**
  - `abort_in` during MARK with 2 entries queued → next cycle enables low, FIFO empty, no `done_out`.
  - `reset_in` mid-SPACE → all outputs 0 in the following cycle.
